// File: rtl/muldiv_ctrl_pkg.sv
// Shared encodings for the multiply/divide sequencer: op codes, FSM states
// and the named levels used on the stall and divider handshake lines.
package muldiv_ctrl_pkg;

    localparam int OP_W = 3;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    localparam logic STOP                 = 1'b1;
    localparam logic NO_STOP              = 1'b0;
    localparam logic DIV_START            = 1'b1;
    localparam logic DIV_STOP             = 1'b0;
    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MUL_WAIT = 2'd1,
        ST_DIV_BUSY = 2'd2,
        ST_DONE     = 2'd3
    } state_t;

    function automatic logic is_mul_op(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_MULTU);
    endfunction

    function automatic logic is_div_op(input logic [2:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic is_signed_op(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_ctrl_if.sv
// Bundle of EX-side request lines, mul/div unit lines and HI/LO write port.
// master is the sequencer side, slave is everything around it.
interface muldiv_ctrl_if
    import muldiv_ctrl_pkg::*;
#(
    parameter int OPW = OP_W
);
    logic            flush;
    logic            op_valid;
    logic [OPW-1:0]  op_code;
    logic [31:0]     src1;
    logic [31:0]     src2;
    logic            stallreq;
    logic            mul_signed;
    logic [31:0]     mul_ina;
    logic [31:0]     mul_inb;
    logic [63:0]     mul_result;
    logic            div_start;
    logic            div_signed;
    logic [31:0]     div_opdata1;
    logic [31:0]     div_opdata2;
    logic            div_annul;
    logic [63:0]     div_result;
    logic            div_ready;
    logic            hi_we;
    logic            lo_we;
    logic [31:0]     hi_wdata;
    logic [31:0]     lo_wdata;

    modport master (
        input  flush, op_valid, op_code, src1, src2, mul_result, div_result, div_ready,
        output stallreq, mul_signed, mul_ina, mul_inb, div_start, div_signed,
               div_opdata1, div_opdata2, div_annul, hi_we, lo_we, hi_wdata, lo_wdata
    );

    modport slave (
        output flush, op_valid, op_code, src1, src2, mul_result, div_result, div_ready,
        input  stallreq, mul_signed, mul_ina, mul_inb, div_start, div_signed,
               div_opdata1, div_opdata2, div_annul, hi_we, lo_we, hi_wdata, lo_wdata
    );

endinterface

// File: rtl/muldiv_lat_cnt.sv
// Loadable down-counter that flags its last count; it times how long the
// sequencer waits for the fixed-latency multiplier.
module muldiv_lat_cnt
    import muldiv_ctrl_pkg::*;
#(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         term
);
    logic [W-1:0] cnt_q, cnt_d;

    // Saturates at zero so an idle counter never wraps back to a live count.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign term = (cnt_q == W'(1));

endmodule

// File: rtl/muldiv_ctrl.sv
// EX-stage multiply/divide sequencer: accepts one op, drives the mul or div
// unit, stalls EX until the result is in, then pulses the HI/LO write port once.
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
#(
    parameter int MUL_LATENCY = 1,
    parameter int OPW         = OP_W
) (
    input  logic          clk,
    input  logic          resetn,
    muldiv_ctrl_if.master bus
);
    state_t         state_q, state_d;
    logic [31:0]    src1_q, src1_d;
    logic [31:0]    src2_q, src2_d;
    logic           signed_q, signed_d;
    logic [63:0]    result_q, result_d;
    logic [OPW-1:0] op_raw;
    logic [2:0]     op;
    logic           op_ok;
    logic           accept_mul;
    logic           accept_div;
    logic           cnt_term;

    assign op_raw     = bus.op_code;
    assign op         = op_raw[2:0];
    assign op_ok      = bus.op_valid && !bus.flush && (state_q == ST_IDLE);
    assign accept_mul = op_ok && is_mul_op(op);
    assign accept_div = op_ok && is_div_op(op);

    muldiv_lat_cnt #(.W(3)) u_lat_cnt (
        .clk      (clk),
        .resetn   (resetn),
        .clear    (bus.flush),
        .load     (accept_mul),
        .load_val (3'(MUL_LATENCY)),
        .dec      (state_q == ST_MUL_WAIT),
        .term     (cnt_term)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            src1_q   <= '0;
            src2_q   <= '0;
            signed_q <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            src1_q   <= src1_d;
            src2_q   <= src2_d;
            signed_q <= signed_d;
            result_q <= result_d;
        end
    end

    // Mul and div results share one capture register: {rem, quot} lines up with {HI, LO}.
    always_comb begin
        state_d  = state_q;
        src1_d   = src1_q;
        src2_d   = src2_q;
        signed_d = signed_q;
        result_d = result_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_mul || accept_div) begin
                    src1_d   = bus.src1;
                    src2_d   = bus.src2;
                    signed_d = is_signed_op(op);
                    state_d  = accept_mul ? ST_MUL_WAIT : ST_DIV_BUSY;
                end
            end
            ST_MUL_WAIT: begin
                if (cnt_term) begin
                    result_d = bus.mul_result;
                    state_d  = ST_DONE;
                end
            end
            ST_DIV_BUSY: begin
                if (bus.div_ready == DIV_RESULT_READY) begin
                    result_d = bus.div_result;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (bus.flush) begin
            state_d = ST_IDLE;
        end
    end

    // Everything is held at zero while resetn is low, whatever the state.
    always_comb begin
        bus.stallreq    = NO_STOP;
        bus.mul_signed  = 1'b0;
        bus.mul_ina     = '0;
        bus.mul_inb     = '0;
        bus.div_start   = DIV_STOP;
        bus.div_signed  = 1'b0;
        bus.div_opdata1 = '0;
        bus.div_opdata2 = '0;
        bus.div_annul   = 1'b0;
        bus.hi_we       = 1'b0;
        bus.lo_we       = 1'b0;
        bus.hi_wdata    = '0;
        bus.lo_wdata    = '0;
        if (resetn) begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.op_valid && !bus.flush) begin
                        if (is_mul_op(op) || is_div_op(op)) begin
                            bus.stallreq = STOP;
                        end
                        if (op == OP_MTHI) begin
                            bus.hi_we    = 1'b1;
                            bus.hi_wdata = bus.src1;
                        end
                        if (op == OP_MTLO) begin
                            bus.lo_we    = 1'b1;
                            bus.lo_wdata = bus.src1;
                        end
                    end
                end
                ST_MUL_WAIT: begin
                    bus.stallreq   = bus.flush ? NO_STOP : STOP;
                    bus.mul_signed = signed_q;
                    bus.mul_ina    = src1_q;
                    bus.mul_inb    = src2_q;
                end
                ST_DIV_BUSY: begin
                    bus.div_signed  = signed_q;
                    bus.div_opdata1 = src1_q;
                    bus.div_opdata2 = src2_q;
                    if (bus.flush) begin
                        bus.div_annul = 1'b1;
                    end else if (bus.div_ready == DIV_RESULT_NOT_READY) begin
                        bus.div_start = DIV_START;
                        bus.stallreq  = STOP;
                    end
                end
                ST_DONE: begin
                    if (!bus.flush) begin
                        bus.hi_we    = 1'b1;
                        bus.lo_we    = 1'b1;
                        bus.hi_wdata = result_q[63:32];
                        bus.lo_wdata = result_q[31:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: directed table, hand-built corner
// sequences and random ops against an op-level timing/arithmetic model.
module tb_muldiv_ctrl;

    localparam int MUL_LAT = 1;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   div_lat = 4;
    int   div_cnt = 0;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          lat;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[11];

    muldiv_ctrl_if #(.OPW(3)) bus ();

    muldiv_ctrl #(.MUL_LATENCY(MUL_LAT), .OPW(3)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // Arithmetic of the external units; divide by zero returns {dividend, all ones}.
    function automatic logic [63:0] mul_unit(input logic s, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb;
        longint unsigned ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        if (s) return 64'(sa * sb);
        return ua * ub;
    endfunction

    function automatic logic [63:0] div_unit(input logic s, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, q, r;
        longint unsigned ua, ub, uq, ur;
        if (b == 32'd0) return {a, 32'hFFFFFFFF};
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        if (s) begin
            q = sa / sb;
            r = sa % sb;
            return {r[31:0], q[31:0]};
        end
        uq = ua / ub;
        ur = ua % ub;
        return {ur[31:0], uq[31:0]};
    endfunction

    function automatic logic [63:0] ref_hilo(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            3'd0:    return mul_unit(1'b1, a, b);
            3'd1:    return mul_unit(1'b0, a, b);
            3'd2:    return div_unit(1'b1, a, b);
            3'd3:    return div_unit(1'b0, a, b);
            3'd4:    return {a, 32'b0};
            3'd5:    return {32'b0, a};
            default: return 64'b0;
        endcase
    endfunction

    always_comb bus.mul_result = mul_unit(bus.mul_signed, bus.mul_ina, bus.mul_inb);
    always_comb bus.div_result = div_unit(bus.div_signed, bus.div_opdata1, bus.div_opdata2);
    always_comb bus.div_ready  = (div_cnt >= div_lat);

    always @(posedge clk) begin
        if (!resetn || !bus.div_start) div_cnt <= 0;
        else                           div_cnt <= div_cnt + 1;
    end

    task automatic applyStimulus(input logic v, input logic [2:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input logic fl);
        bus.op_valid = v;
        bus.op_code  = op;
        bus.src1     = a;
        bus.src2     = b;
        bus.flush    = fl;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic any_output();
        return |{bus.stallreq, bus.mul_signed, bus.mul_ina, bus.mul_inb, bus.div_start,
                 bus.div_signed, bus.div_opdata1, bus.div_opdata2, bus.div_annul,
                 bus.hi_we, bus.lo_we, bus.hi_wdata, bus.lo_wdata};
    endfunction

    // One op from accept to a few idle cycles after its write; sources are scrambled after accept.
    task automatic do_op(input string name, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int lat, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int          w, exp_stall, exp_start, hold, stall_n, start_n, pulses, wcyc;
        logic        exp_hwe, exp_lwe, got_hwe, got_lwe;
        logic [31:0] got_hi, got_lo;
        w = -1; exp_stall = 0; exp_start = 0; exp_hwe = 1'b0; exp_lwe = 1'b0;
        if (op == 3'd0 || op == 3'd1) begin
            w = MUL_LAT + 1; exp_stall = w; exp_hwe = 1'b1; exp_lwe = 1'b1;
        end else if (op == 3'd2 || op == 3'd3) begin
            w = lat + 2; exp_stall = lat + 1; exp_start = lat; exp_hwe = 1'b1; exp_lwe = 1'b1;
        end else if (op == 3'd4) begin
            w = 0; exp_hwe = 1'b1;
        end else if (op == 3'd5) begin
            w = 0; exp_lwe = 1'b1;
        end
        hold = (w < 0) ? 0 : w;
        div_lat = lat;
        stall_n = 0; start_n = 0; pulses = 0; wcyc = -1;
        got_hwe = 1'b0; got_lwe = 1'b0; got_hi = '0; got_lo = '0;
        for (int k = 0; k <= hold + 3; k++) begin
            @(negedge clk);
            if (k == 0) applyStimulus(1'b1, op, a, b, 1'b0);
            else if (k == 1) begin
                bus.src1 = $urandom;
                bus.src2 = $urandom;
            end
            if (k == hold + 1) bus.op_valid = 1'b0;
            #1;
            if (bus.stallreq)  stall_n++;
            if (bus.div_start) start_n++;
            if (bus.hi_we || bus.lo_we) begin
                pulses++;
                if (wcyc < 0) begin
                    wcyc = k; got_hwe = bus.hi_we; got_lwe = bus.lo_we;
                    got_hi = bus.hi_wdata; got_lo = bus.lo_wdata;
                end
            end
        end
        checkOutput({name, " write_cycle"}, 64'(wcyc), 64'(w));
        checkOutput({name, " pulses"}, 64'(pulses), (w < 0) ? 64'd0 : 64'd1);
        checkOutput({name, " stall_cycles"}, 64'(stall_n), 64'(exp_stall));
        checkOutput({name, " start_cycles"}, 64'(start_n), 64'(exp_start));
        if (w >= 0) begin
            checkOutput({name, " we_flags"}, {62'b0, got_hwe, got_lwe}, {62'b0, exp_hwe, exp_lwe});
            if (exp_hwe) checkOutput({name, " hi_wdata"}, 64'(got_hi), 64'(exp_hi));
            if (exp_lwe) checkOutput({name, " lo_wdata"}, 64'(got_lo), 64'(exp_lo));
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [2:0]  r_op;
        logic [31:0] r_a, r_b;
        logic [63:0] r_exp;
        int          r_lat, pulses;

        vecs[0]  = '{"mult_neg",      3'd0, 32'hFFFFFFFD, 32'd5,        1,  32'hFFFFFFFF, 32'hFFFFFFF1};
        vecs[1]  = '{"divu_100_7",    3'd3, 32'd100,      32'd7,        34, 32'h00000002, 32'h0000000E};
        vecs[2]  = '{"div_neg",       3'd2, 32'hFFFFFFF9, 32'd2,        5,  32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3]  = '{"mthi",          3'd4, 32'h12345678, 32'd0,        1,  32'h12345678, 32'h0};
        vecs[4]  = '{"mtlo",          3'd5, 32'hCAFEF00D, 32'hFFFF,     1,  32'h0,        32'hCAFEF00D};
        vecs[5]  = '{"multu_max",     3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1,  32'hFFFFFFFE, 32'h00000001};
        vecs[6]  = '{"mult_min",      3'd0, 32'h80000000, 32'h80000000, 1,  32'h40000000, 32'h0};
        vecs[7]  = '{"divu_zero",     3'd3, 32'h55,       32'd0,        3,  32'h00000055, 32'hFFFFFFFF};
        vecs[8]  = '{"div_neg_dvsr",  3'd2, 32'd100,      32'hFFFFFFF9, 2,  32'h00000002, 32'hFFFFFFF2};
        vecs[9]  = '{"invalid_6",     3'd6, 32'd1,        32'd2,        1,  32'h0,        32'h0};
        vecs[10] = '{"invalid_7",     3'd7, 32'd3,        32'd4,        1,  32'h0,        32'h0};

        applyStimulus(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        #1;
        checkOutput("reset_outputs", {63'b0, any_output()}, 64'd0);

        for (int i = 0; i < 11; i++) begin
            do_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].lat, vecs[i].hi, vecs[i].lo);
        end

        // MULT write followed immediately by MTLO in the first IDLE cycle.
        @(negedge clk); applyStimulus(1'b1, 3'd0, 32'd7, 32'd6, 1'b0);
        repeat (MUL_LAT + 1) @(negedge clk);
        #1;
        checkOutput("b2b mul_we", {62'b0, bus.hi_we, bus.lo_we}, 64'd3);
        checkOutput("b2b mul_lo", 64'(bus.lo_wdata), 64'd42);
        @(negedge clk); applyStimulus(1'b1, 3'd5, 32'hBEEF, 32'd0, 1'b0);
        #1;
        checkOutput("b2b mtlo_we", {62'b0, bus.hi_we, bus.lo_we}, 64'd1);
        checkOutput("b2b mtlo_data", 64'(bus.lo_wdata), 64'hBEEF);
        checkOutput("b2b mtlo_stall", 64'(bus.stallreq), 64'd0);
        @(negedge clk); applyStimulus(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        #1;
        checkOutput("b2b idle_we", {62'b0, bus.hi_we, bus.lo_we}, 64'd0);

        // Flush lands in the same cycle the divider reports ready.
        div_lat = 8;
        @(negedge clk); applyStimulus(1'b1, 3'd2, 32'd50, 32'd3, 1'b0);
        repeat (5) @(negedge clk);
        #1;
        checkOutput("flush busy_start", 64'(bus.div_start), 64'd1);
        checkOutput("flush busy_stall", 64'(bus.stallreq), 64'd1);
        repeat (4) @(negedge clk);
        bus.flush = 1'b1;
        #1;
        checkOutput("flush annul", 64'(bus.div_annul), 64'd1);
        checkOutput("flush start", 64'(bus.div_start), 64'd0);
        checkOutput("flush we", {62'b0, bus.hi_we, bus.lo_we}, 64'd0);
        checkOutput("flush stall", 64'(bus.stallreq), 64'd0);
        @(negedge clk); applyStimulus(1'b1, 3'd5, 32'hA5A5, 32'd0, 1'b0);
        #1;
        checkOutput("post_flush stall", 64'(bus.stallreq), 64'd0);
        checkOutput("post_flush mtlo_we", {62'b0, bus.hi_we, bus.lo_we}, 64'd1);
        @(negedge clk); applyStimulus(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        #1;
        checkOutput("post_flush idle_we", {62'b0, bus.hi_we, bus.lo_we}, 64'd0);

        // Flush in IDLE blocks both MTHI writes and acceptance.
        @(negedge clk); applyStimulus(1'b1, 3'd4, 32'hDEAD, 32'd0, 1'b1);
        #1;
        checkOutput("idle_flush mthi_we", 64'(bus.hi_we), 64'd0);
        @(negedge clk); applyStimulus(1'b1, 3'd0, 32'd3, 32'd3, 1'b1);
        #1;
        checkOutput("idle_flush mul_stall", 64'(bus.stallreq), 64'd0);
        @(negedge clk); applyStimulus(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        #1;
        checkOutput("idle_flush not_accepted", 64'(bus.stallreq), 64'd0);

        // Reset in MUL_WAIT discards the multiply.
        @(negedge clk); applyStimulus(1'b1, 3'd0, 32'd5, 32'd5, 1'b0);
        #1;
        checkOutput("rst accept_stall", 64'(bus.stallreq), 64'd1);
        @(negedge clk); resetn = 1'b0; bus.op_valid = 1'b0;
        @(negedge clk); resetn = 1'b1;
        #1;
        checkOutput("rst outputs", {63'b0, any_output()}, 64'd0);
        pulses = 0;
        repeat (3) begin
            @(negedge clk); #1;
            if (bus.hi_we || bus.lo_we) pulses++;
        end
        checkOutput("rst no_write", 64'(pulses), 64'd0);
        do_op("multu_3x4", 3'd1, 32'd3, 32'd4, 1, 32'd0, 32'd12);

        for (int i = 0; i < 40; i++) begin
            r_op  = 3'($urandom_range(0, 7));
            r_a   = $urandom;
            r_b   = ($urandom_range(0, 9) == 0) ? 32'd0 :
                    ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 100)) : $urandom;
            r_lat = $urandom_range(1, 12);
            r_exp = ref_hilo(r_op, r_a, r_b);
            do_op($sformatf("rnd%0d_op%0d", i, r_op), r_op, r_a, r_b, r_lat, r_exp[63:32], r_exp[31:0]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
